// File: rtl/periph_ctrl_target_pkg.sv
// Shared register map, controller state encoding and byte-merge helper
// for the peripheral job-control target.
package periph_ctrl_target_pkg;

   localparam logic [7:0]  TRIGGER      = 8'h00;
   localparam logic [7:0]  ACQUIRE      = 8'h04;
   localparam logic [7:0]  FINISHED     = 8'h08;
   localparam logic [7:0]  STATUS       = 8'h0C;
   localparam logic [7:0]  RUNNING_JOB  = 8'h10;
   localparam logic [7:0]  SOFT_CLEAR   = 8'h14;
   localparam logic [7:0]  JOB_REG_BASE = 8'h40;

   localparam logic [31:0] ACQUIRE_BUSY = 32'h0000_0001;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACQUIRED = 2'd1,
      ST_RUNNING  = 2'd2,
      ST_CLEARING = 2'd3
   } ctrl_state_e;

   function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/periph_ctrl_regfile.sv
// Byte-enabled job register array; clr_i zeroes every word in one cycle
// and takes priority over a same-cycle write.
module periph_ctrl_regfile
   import periph_ctrl_target_pkg::*;
#(
   parameter int N_JOB_REGS = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clr_i,
   input  logic                     we_i,
   input  logic [5:0]               idx_i,
   input  logic [3:0]               be_i,
   input  logic [31:0]              wdata_i,
   output logic [32*N_JOB_REGS-1:0] regs_o
);

   logic [31:0] r_regs [N_JOB_REGS];

   // Register storage with synchronous reset/clear and byte-wise writes
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < N_JOB_REGS; k++) begin
         if (rst_i || clr_i) begin
            r_regs[k] <= 32'h0;
         end else if (we_i && (idx_i == 6'(k))) begin
            r_regs[k] <= be_merge(r_regs[k], wdata_i, be_i);
         end else begin
            r_regs[k] <= r_regs[k];
         end
      end
   end

   // Flatten the array onto the engine-facing bus
   always_comb begin
      regs_o = '0;
      for (int k = 0; k < N_JOB_REGS; k++) begin
         regs_o[32*k +: 32] = r_regs[k];
      end
   end

endmodule

// File: rtl/periph_ctrl_target.sv
// Peripheral-bus target implementing the acquire/program/trigger/clear job
// protocol in front of one datamover engine.
module periph_ctrl_target
   import periph_ctrl_target_pkg::*;
#(
   parameter int N_JOB_REGS        = 16,
   parameter int ID_WIDTH          = 8,
   parameter int SOFT_CLEAR_CYCLES = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     periph_req_i,
   output logic                     periph_gnt_o,
   input  logic [31:0]              periph_add_i,
   input  logic                     periph_wen_i,
   input  logic [3:0]               periph_be_i,
   input  logic [31:0]              periph_data_i,
   input  logic [ID_WIDTH-1:0]      periph_id_i,
   output logic [31:0]              periph_r_data_o,
   output logic                     periph_r_valid_o,
   output logic [ID_WIDTH-1:0]      periph_r_id_o,
   output logic [32*N_JOB_REGS-1:0] job_regs_o,
   output logic                     start_o,
   output logic                     clear_o,
   input  logic                     done_i,
   output logic                     evt_o
);

   localparam int         CNT_W   = $clog2(SOFT_CLEAR_CYCLES + 1);
   localparam logic [6:0] N_JOB_L = 7'(N_JOB_REGS);

   ctrl_state_e      r_state;
   logic [CNT_W-1:0] r_clr_cnt;
   logic [7:0]       r_job_id;
   logic [31:0]      r_finished;

   logic [7:0]  w_off;
   logic [5:0]  w_job_k;
   logic        w_xfer;
   logic        w_rd;
   logic        w_wr;
   logic        w_is_jobreg;
   logic        w_job_we;
   logic        w_acq_rd;
   logic        w_trig_wr;
   logic        w_soft_clr;
   logic [31:0] w_rdata;
   logic [31:0] w_job_rd;
   logic        w_unused;

   assign w_unused = ^{periph_add_i[31:8], periph_add_i[1:0]};

   assign periph_gnt_o = periph_req_i && (r_state != ST_CLEARING);

   assign w_off       = {periph_add_i[7:2], 2'b00};
   assign w_job_k     = w_off[7:2] - JOB_REG_BASE[7:2];
   assign w_xfer      = periph_req_i && periph_gnt_o;
   assign w_rd        = w_xfer && periph_wen_i;
   assign w_wr        = w_xfer && !periph_wen_i;
   assign w_is_jobreg = (w_off >= JOB_REG_BASE) && ({1'b0, w_job_k} < N_JOB_L);
   assign w_job_we    = w_wr && w_is_jobreg && (r_state == ST_ACQUIRED);
   assign w_acq_rd    = w_rd && (w_off == ACQUIRE);
   assign w_trig_wr   = w_wr && (w_off == TRIGGER);
   assign w_soft_clr  = w_wr && (w_off == SOFT_CLEAR);

   periph_ctrl_regfile #(
      .N_JOB_REGS (N_JOB_REGS)
   ) u_regfile (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (w_soft_clr),
      .we_i    (w_job_we),
      .idx_i   (w_job_k),
      .be_i    (periph_be_i),
      .wdata_i (periph_data_i),
      .regs_o  (job_regs_o)
   );

   // Job register read selection from the flattened register bus
   always_comb begin
      w_job_rd = 32'h0;
      for (int k = 0; k < N_JOB_REGS; k++) begin
         if (w_job_k == 6'(k)) begin
            w_job_rd = job_regs_o[32*k +: 32];
         end else begin
            w_job_rd = w_job_rd;
         end
      end
   end

   // Read data uses pre-update state, so ACQUIRE sees the state it is leaving
   always_comb begin
      w_rdata = 32'h0;
      case (w_off)
         ACQUIRE:     w_rdata = (r_state == ST_IDLE) ? 32'h0 : ACQUIRE_BUSY;
         FINISHED:    w_rdata = r_finished;
         STATUS:      w_rdata = {31'h0, (r_state != ST_IDLE)};
         RUNNING_JOB: w_rdata = {24'h0, r_job_id};
         default: begin
            if (w_is_jobreg) begin
               w_rdata = w_job_rd;
            end else begin
               w_rdata = 32'h0;
            end
         end
      endcase
   end

   // Single-cycle response pipe: every granted access answers next cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         periph_r_valid_o <= 1'b0;
         periph_r_data_o  <= 32'h0;
         periph_r_id_o    <= '0;
      end else begin
         periph_r_valid_o <= w_xfer;
         periph_r_data_o  <= w_rd ? w_rdata : 32'h0;
         periph_r_id_o    <= w_xfer ? periph_id_i : periph_r_id_o;
      end
   end

   // Job-control FSM; soft clear overrides any same-cycle done_i
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_clr_cnt  <= '0;
         r_job_id   <= 8'h0;
         r_finished <= 32'h0;
         start_o    <= 1'b0;
         clear_o    <= 1'b0;
         evt_o      <= 1'b0;
      end else begin
         start_o <= 1'b0;
         evt_o   <= 1'b0;
         if (w_soft_clr) begin
            r_state    <= ST_CLEARING;
            r_clr_cnt  <= CNT_W'(SOFT_CLEAR_CYCLES - 1);
            r_job_id   <= 8'h0;
            r_finished <= 32'h0;
            clear_o    <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_acq_rd) begin
                     r_state  <= ST_ACQUIRED;
                     r_job_id <= r_job_id + 8'd1;
                  end
               end
               ST_ACQUIRED: begin
                  if (w_trig_wr) begin
                     r_state <= ST_RUNNING;
                     start_o <= 1'b1;
                  end
               end
               ST_RUNNING: begin
                  if (done_i) begin
                     r_state    <= ST_IDLE;
                     evt_o      <= 1'b1;
                     r_finished <= r_finished + 32'd1;
                  end
               end
               ST_CLEARING: begin
                  if (r_clr_cnt == '0) begin
                     r_state <= ST_IDLE;
                     clear_o <= 1'b0;
                  end else begin
                     r_clr_cnt <= r_clr_cnt - CNT_W'(1);
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_periph_ctrl_target.sv
// Scoreboard bench for periph_ctrl_target: expected responses are queued
// as each access is driven and compared when r_valid returns.
module tb_periph_ctrl_target;

   logic          clk = 1'b0;
   logic          rst;
   logic          req, wen, done;
   logic [31:0]   add, wdata;
   logic [3:0]    be;
   logic [7:0]    id;
   logic          gnt, rvalid, start, clear, evt;
   logic [31:0]   rdata;
   logic [7:0]    rid;
   logic [511:0]  job_regs;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            run      = 0;
   int            run_max  = 0;
   logic [39:0]   exp_q[$];

   always #5 clk = ~clk;

   periph_ctrl_target #(
      .N_JOB_REGS(16), .ID_WIDTH(8), .SOFT_CLEAR_CYCLES(4)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .periph_req_i     (req),
      .periph_gnt_o     (gnt),
      .periph_add_i     (add),
      .periph_wen_i     (wen),
      .periph_be_i      (be),
      .periph_data_i    (wdata),
      .periph_id_i      (id),
      .periph_r_data_o  (rdata),
      .periph_r_valid_o (rvalid),
      .periph_r_id_o    (rid),
      .job_regs_o       (job_regs),
      .start_o          (start),
      .clear_o          (clear),
      .done_i           (done),
      .evt_o            (evt)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // Response monitor: pops the scoreboard on every r_valid
   always @(negedge clk) begin
      logic [39:0] e;
      if (rvalid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_rvalid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("rdata", rdata, e[31:0]);
            check_eq("rid", {24'h0, rid}, {24'h0, e[39:32]});
         end
         run++;
         if (run > run_max) run_max = run;
      end else begin
         run = 0;
      end
   end

   task automatic txn(input logic a_wen, input logic [31:0] a_add, input logic [31:0] a_data,
                      input logic [3:0] a_be, input logic [7:0] a_id,
                      input logic [31:0] a_exp, input logic a_done);
      int n;
      req = 1'b1; wen = a_wen; add = a_add; wdata = a_data; be = a_be; id = a_id; done = a_done;
      #1;
      n = 0;
      while (!gnt && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!gnt) begin
         check_eq("gnt_wait", 32'd0, 32'd1);
         req = 1'b0; done = 1'b0;
      end else begin
         exp_q.push_back({a_id, a_exp});
         @(posedge clk); #1;
         req = 1'b0; done = 1'b0;
         check_eq("rvalid_latency", {31'h0, rvalid}, 32'd1);
      end
   endtask

   task automatic rd(input logic [31:0] a_add, input logic [7:0] a_id, input logic [31:0] a_exp);
      txn(1'b1, a_add, 32'h0, 4'h0, a_id, a_exp, 1'b0);
   endtask

   task automatic wr(input logic [31:0] a_add, input logic [31:0] a_data, input logic [3:0] a_be,
                     input logic [7:0] a_id);
      txn(1'b0, a_add, a_data, a_be, a_id, 32'h0, 1'b0);
   endtask

   task automatic pulse_done(input logic exp_evt);
      done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      check_eq("evt_pulse", {31'h0, evt}, {31'h0, exp_evt});
      @(posedge clk); #1;
      check_eq("evt_drop", {31'h0, evt}, 32'd0);
   endtask

   task automatic wait_clear_end();
      int n;
      n = 0;
      while (clear && n < 10) begin
         @(posedge clk); #1; n++;
      end
      check_eq("clear_end", {31'h0, clear}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req = 1'b0; wen = 1'b0; done = 1'b0;
      add = 32'h0; wdata = 32'h0; be = 4'h0; id = 8'h0;
      repeat (2) @(posedge clk);
      #1;
      req = 1'b1; #1;
      check_eq("gnt_follows_req_hi", {31'h0, gnt}, 32'd1);
      req = 1'b0; #1;
      check_eq("gnt_follows_req_lo", {31'h0, gnt}, 32'd0);
      rst = 1'b0;
      check_eq("rst_rvalid", {31'h0, rvalid}, 32'd0);
      check_eq("rst_rdata", rdata, 32'd0);
      check_eq("rst_outs", {29'h0, start, clear, evt}, 32'd0);
      check_eq("rst_jobregs", {31'h0, (job_regs != '0)}, 32'd0);

      // Acquire handshake and status
      rd(32'h04, 8'h01, 32'h0);
      rd(32'h0C, 8'h02, 32'h1);
      rd(32'h04, 8'h03, 32'h1);
      rd(32'h10, 8'h04, 32'h1);

      // Byte-enabled job register programming and decode boundaries
      wr(32'h40, 32'hA5A5A5A5, 4'b0011, 8'h10);
      rd(32'h40, 8'h11, 32'h0000A5A5);
      wr(32'h44, 32'h12345678, 4'b1111, 8'h12);
      wr(32'h40, 32'hDEADBEEF, 4'b1100, 8'h13);
      rd(32'h40, 8'h14, 32'hDEADA5A5);
      check_eq("jobreg0_bus", job_regs[31:0], 32'hDEADA5A5);
      rd(32'h3C, 8'h15, 32'h0);
      rd(32'h80, 8'h16, 32'h0);
      rd(32'h144, 8'h17, 32'h12345678);

      // Trigger, writes dropped while running, repeated trigger ignored
      wr(32'h00, 32'h0, 4'hF, 8'h18);
      check_eq("start_pulse", {31'h0, start}, 32'd1);
      rd(32'h0C, 8'h19, 32'h1);
      check_eq("start_drop", {31'h0, start}, 32'd0);
      wr(32'h48, 32'hCAFEF00D, 4'hF, 8'h1A);
      rd(32'h48, 8'h1B, 32'h0);
      wr(32'h00, 32'h0, 4'hF, 8'h1C);
      check_eq("retrigger_no_start", {31'h0, start}, 32'd0);

      // Completion, then done outside RUNNING and write in IDLE
      pulse_done(1'b1);
      rd(32'h0C, 8'h1D, 32'h0);
      rd(32'h08, 8'h1E, 32'h1);
      pulse_done(1'b0);
      rd(32'h08, 8'h1F, 32'h1);
      wr(32'h4C, 32'h11111111, 4'hF, 8'h20);
      rd(32'h4C, 8'h21, 32'h0);

      // Soft clear in RUNNING: clear_o and gnt blocking window
      rd(32'h04, 8'h22, 32'h0);
      wr(32'h00, 32'h0, 4'hF, 8'h23);
      wr(32'h14, 32'hF0CACC1A, 4'hF, 8'h24);
      req = 1'b1; wen = 1'b1; add = 32'h0C; id = 8'h25;
      #1;
      for (int i = 0; i < 4; i++) begin
         check_eq("clear_high", {31'h0, clear}, 32'd1);
         check_eq("gnt_low_clearing", {31'h0, gnt}, 32'd0);
         @(posedge clk); #1;
      end
      check_eq("clear_low_after", {31'h0, clear}, 32'd0);
      check_eq("gnt_back", {31'h0, gnt}, 32'd1);
      exp_q.push_back({8'h25, 32'h0});
      @(posedge clk); #1;
      req = 1'b0;
      rd(32'h08, 8'h26, 32'h0);
      rd(32'h40, 8'h27, 32'h0);
      rd(32'h44, 8'h28, 32'h0);
      rd(32'h10, 8'h29, 32'h0);
      check_eq("clr_jobregs", {31'h0, (job_regs != '0)}, 32'd0);

      // Soft clear together with done: clear wins
      rd(32'h04, 8'h30, 32'h0);
      wr(32'h00, 32'h0, 4'hF, 8'h31);
      txn(1'b0, 32'h14, 32'h0, 4'hF, 8'h32, 32'h0, 1'b1);
      check_eq("clr_done_no_evt", {31'h0, evt}, 32'd0);
      wait_clear_end();
      check_eq("clr_done_no_evt2", {31'h0, evt}, 32'd0);
      rd(32'h08, 8'h33, 32'h0);

      // ACQUIRE read together with done
      rd(32'h04, 8'h34, 32'h0);
      wr(32'h00, 32'h0, 4'hF, 8'h35);
      txn(1'b1, 32'h04, 32'h0, 4'h0, 8'h36, 32'h1, 1'b1);
      check_eq("acq_done_evt", {31'h0, evt}, 32'd1);
      rd(32'h04, 8'h37, 32'h0);
      rd(32'h08, 8'h38, 32'h1);
      rd(32'h10, 8'h39, 32'h2);

      // Back-to-back reads
      @(posedge clk); #1;
      run_max = 0;
      rd(32'h0C, 8'h03, 32'h1);
      rd(32'h08, 8'h04, 32'h1);
      rd(32'h04, 8'h05, 32'h1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("b2b_run", run_max, 32'd3);

      // Reset mid-RUNNING with an access in flight
      wr(32'h40, 32'hFFFFFFFF, 4'hF, 8'h40);
      wr(32'h00, 32'h0, 4'hF, 8'h41);
      req = 1'b1; wen = 1'b1; add = 32'h04; id = 8'h77; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; req = 1'b0;
      check_eq("mid_rst_rvalid", {31'h0, rvalid}, 32'd0);
      check_eq("mid_rst_rdata", rdata, 32'd0);
      check_eq("mid_rst_rid", {24'h0, rid}, 32'd0);
      check_eq("mid_rst_outs", {29'h0, start, clear, evt}, 32'd0);
      check_eq("mid_rst_jobregs", {31'h0, (job_regs != '0)}, 32'd0);
      rd(32'h10, 8'h42, 32'h0);
      rd(32'h04, 8'h43, 32'h0);
      rd(32'h10, 8'h44, 32'h1);

      repeat (3) @(posedge clk);
      #1;
      check_eq("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
